// File: rtl/peripheral_ahb4_verilog_pkg.sv
// ---------------------------------------------------------------------------
// peripheral_ahb4_verilog_pkg
// Shared AHB-Lite constants plus the CPU->AHB scoreboard entry type.
//   HTRANS_* / HSIZE_*  : AHB encodings
//   sb_entry_t          : one expected transfer {adr, we, be, d}, sized for
//                         the widest supported bus (XLEN=64); narrower users
//                         zero-extend into it
//   sb_err_e            : index of each scoreboard error counter
//   be2size()           : byte-enable pattern -> {valid, HSIZE[1:0]}
// ---------------------------------------------------------------------------
package peripheral_ahb4_verilog_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam int SB_ADR_W  = 64;
  localparam int SB_DATA_W = 64;
  localparam int SB_BE_W   = SB_DATA_W / 8;

  typedef struct packed {
    logic [SB_ADR_W-1:0]  adr;
    logic                 we;
    logic [SB_BE_W-1:0]   be;
    logic [SB_DATA_W-1:0] d;
  } sb_entry_t;

  typedef enum int unsigned {
    ERR_ADDR  = 0,
    ERR_WRITE = 1,
    ERR_SIZE  = 2,
    ERR_WDATA = 3,
    ERR_RESP  = 4
  } sb_err_e;

  localparam int NUM_ERR = 5;

  // Only naturally aligned power-of-two lane groups are encodable. On a
  // 32-bit bus the upper four enables are always zero, so 8'hFF never occurs.
  function automatic logic [2:0] be2size(input logic [SB_BE_W-1:0] be);
    case (be)
      8'h01, 8'h02, 8'h04, 8'h08,
      8'h10, 8'h20, 8'h40, 8'h80: return {1'b1, HSIZE_BYTE[1:0]};
      8'h03, 8'h0C, 8'h30, 8'hC0: return {1'b1, HSIZE_HWORD[1:0]};
      8'h0F, 8'hF0:               return {1'b1, HSIZE_WORD[1:0]};
      8'hFF:                      return {1'b1, HSIZE_DWORD[1:0]};
      default:                    return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/soc_riscv_check_fifo.sv
// ---------------------------------------------------------------------------
// soc_riscv_check_fifo
// Synchronous FIFO holding expected transfers. Head data is read straight
// from storage, so an entry written this cycle cannot be popped this cycle.
//   clk, rst_n    : clock, async active-low reset
//   i_push/i_pop  : requests; a push while full is accepted only with a pop
//   i_wdata       : data pushed
//   o_rdata       : head entry
//   o_empty       : no entries
//   o_count       : number of entries (0..DEPTH)
//   o_overflow    : pulse, push dropped because full and not popping
//   o_underflow   : pulse, pop requested while empty
// ---------------------------------------------------------------------------
module soc_riscv_check_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_rdata     = r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_overflow  = i_push && w_full && !w_do_pop;
  assign o_underflow = i_pop && o_empty;

  // NOTE: pointers and count are reset; storage is not, since a slot is
  // never read before it is written and a reset net on every bit buys nothing.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/soc_riscv_check_cpu2ahb_scoreboard.sv
// ---------------------------------------------------------------------------
// soc_riscv_check_cpu2ahb_scoreboard
// Watches a CPU memory port and the AHB-Lite master port derived from it.
// Aligned CPU requests are queued; each AHB address phase pops one and checks
// HADDR/HWRITE/HSIZE, then its data phase checks lane-masked HWDATA and HRESP.
//   HCLK, HRESETn            : clock, async active-low reset
//   mem_*                    : CPU request port (pushes expected entries)
//   HSEL..HRESP              : AHB-Lite bus being checked
//   pending                  : outstanding expected entries
//   err_*_cnt                : saturating mismatch counters
//   overflow / underflow     : sticky queue-misuse flags
//   err_any                  : any counter non-zero or any sticky flag set
// Optional: define SOC_RISCV_CHECK_CPU2AHB_DISPLAY_EN to print an
// "ERROR  :" line for every counted mismatch, overflow or underflow.
// ---------------------------------------------------------------------------
module soc_riscv_check_cpu2ahb_scoreboard
  import peripheral_ahb4_verilog_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int PHYS_ADDR_SIZE = XLEN,
  parameter int DEPTH          = 4,
  parameter int CNT_W          = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [XLEN-1:0]           mem_adr,
  input  logic [XLEN-1:0]           mem_d,
  input  logic                      mem_req,
  input  logic                      mem_we,
  input  logic [XLEN/8-1:0]         mem_be,
  input  logic                      mem_misaligned,
  input  logic                      HSEL,
  input  logic [PHYS_ADDR_SIZE-1:0] HADDR,
  input  logic [XLEN-1:0]           HWDATA,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [1:0]                HTRANS,
  input  logic                      HREADY,
  input  logic                      HRESP,
  output logic [$clog2(DEPTH):0]    pending,
  output logic [CNT_W-1:0]          err_addr_cnt,
  output logic [CNT_W-1:0]          err_write_cnt,
  output logic [CNT_W-1:0]          err_size_cnt,
  output logic [CNT_W-1:0]          err_wdata_cnt,
  output logic [CNT_W-1:0]          err_resp_cnt,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      err_any
);

  // Only the low PHYS_ADDR_SIZE address bits take part in the compare.
  localparam logic [SB_ADR_W-1:0] ADR_MASK = ~({SB_ADR_W{1'b1}} << PHYS_ADDR_SIZE);

  sb_entry_t            w_push_entry;
  sb_entry_t            w_head;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_pop_ok;
  logic                 w_empty;
  logic                 w_ovf;
  logic                 w_unf;
  logic [2:0]           w_size;
  logic                 w_dp_done;
  logic [SB_DATA_W-1:0] w_lane_mask;
  logic [NUM_ERR-1:0]   w_inc;

  logic                 r_dp_valid;
  logic                 r_dp_we;
  logic [SB_BE_W-1:0]   r_dp_be;
  logic [SB_DATA_W-1:0] r_dp_d;
  logic [CNT_W-1:0]     r_cnt [NUM_ERR];
  logic                 r_overflow;
  logic                 r_underflow;
  logic                 r_err_any;

  assign w_push       = mem_req && !mem_misaligned;
  assign w_pop        = HREADY && HSEL && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign w_push_entry = '{adr: SB_ADR_W'(mem_adr), we: mem_we,
                          be: SB_BE_W'(mem_be), d: SB_DATA_W'(mem_d)};

  soc_riscv_check_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(sb_entry_t))
  ) u_fifo (
    .clk         (HCLK),
    .rst_n       (HRESETn),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_wdata     (w_push_entry),
    .o_rdata     (w_head),
    .o_empty     (w_empty),
    .o_count     (pending),
    .o_overflow  (w_ovf),
    .o_underflow (w_unf)
  );

  // A pop on an empty queue only raises underflow: nothing to compare.
  assign w_pop_ok  = w_pop && !w_empty;
  assign w_size    = be2size(w_head.be);
  assign w_dp_done = r_dp_valid && HREADY;

  // NOTE: every always_comb output gets a default first so no latch forms.
  always_comb begin
    w_lane_mask = '0;
    for (int b = 0; b < SB_BE_W; b++) w_lane_mask[8*b +: 8] = {8{r_dp_be[b]}};
  end

  assign w_inc[ERR_ADDR]  = w_pop_ok && (((w_head.adr ^ SB_ADR_W'(HADDR)) & ADR_MASK) != '0);
  assign w_inc[ERR_WRITE] = w_pop_ok && (HWRITE != w_head.we);
  assign w_inc[ERR_SIZE]  = w_pop_ok && (!w_size[2] || HSIZE != {1'b0, w_size[1:0]});
  assign w_inc[ERR_WDATA] = w_dp_done && r_dp_we &&
                            (((SB_DATA_W'(HWDATA) ^ r_dp_d) & w_lane_mask) != '0);
  assign w_inc[ERR_RESP]  = w_dp_done && HRESP;

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_ERR; i++) r_cnt[i] <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_err_any   <= 1'b0;
      r_dp_valid  <= 1'b0;
      r_dp_we     <= 1'b0;
      r_dp_be     <= '0;
      r_dp_d      <= '0;
    end else begin
      for (int i = 0; i < NUM_ERR; i++) begin
        if (w_inc[i] && r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
      r_overflow  <= r_overflow  | w_ovf;
      r_underflow <= r_underflow | w_unf;
      // Counters never decrease, so a sticky OR of events equals "any non-zero".
      r_err_any   <= r_err_any | (|w_inc) | w_ovf | w_unf;
      // An address phase in the completing cycle reloads (back-to-back);
      // a wait state (HREADY=0) holds; a plain completion empties.
      if (w_pop_ok) begin
        r_dp_valid <= 1'b1;
        r_dp_we    <= w_head.we;
        r_dp_be    <= w_head.be;
        r_dp_d     <= w_head.d;
      end else if (HREADY) begin
        r_dp_valid <= 1'b0;
      end
    end
  end

  assign err_addr_cnt  = r_cnt[ERR_ADDR];
  assign err_write_cnt = r_cnt[ERR_WRITE];
  assign err_size_cnt  = r_cnt[ERR_SIZE];
  assign err_wdata_cnt = r_cnt[ERR_WDATA];
  assign err_resp_cnt  = r_cnt[ERR_RESP];
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;
  assign err_any       = r_err_any;

`ifdef SOC_RISCV_CHECK_CPU2AHB_DISPLAY_EN
  always @(posedge HCLK) begin
    if (HRESETn) begin
      if (w_inc[ERR_ADDR])
        $display("ERROR  : %m HADDR got=%h expected=%h at %0t", HADDR, w_head.adr, $time);
      if (w_inc[ERR_WRITE])
        $display("ERROR  : %m HWRITE got=%b expected=%b at %0t", HWRITE, w_head.we, $time);
      if (w_inc[ERR_SIZE])
        $display("ERROR  : %m HSIZE got=%0d expected=%0d (be=%h) at %0t",
                 HSIZE, w_size[1:0], w_head.be, $time);
      if (w_inc[ERR_WDATA])
        $display("ERROR  : %m HWDATA got=%h expected=%h mask=%h at %0t",
                 HWDATA, r_dp_d, w_lane_mask, $time);
      if (w_inc[ERR_RESP])
        $display("ERROR  : %m HRESP got=1 expected=0 at %0t", $time);
      if (w_ovf)
        $display("ERROR  : %m overflow: push while full (pending=%0d) at %0t", pending, $time);
      if (w_unf)
        $display("ERROR  : %m underflow: AHB transfer with no expected entry at %0t", $time);
    end
  end
`endif

endmodule

// File: doc/soc_riscv_check_cpu2ahb_scoreboard.md
Name: soc_riscv_check_cpu2ahb_scoreboard

Overview:
Parametrised, depth-bounded bus scoreboard that monitors a CPU memory port and the AHB-Lite master port generated from it.
- Every aligned CPU request is checked against its AHB address phase (HADDR, HWRITE, HSIZE) and its data phase (byte-lane-masked HWDATA, HRESP).
- Supports up to DEPTH outstanding requests.
- Reports results through saturating error counters and sticky flags, so benches and formal harnesses can assert on them without parsing log text.

Parameters:
- XLEN, 32, data width (32 or 64).
- PHYS_ADDR_SIZE, XLEN, compared address width.
- DEPTH, 4, maximum outstanding CPU requests (power of 2, >=2).
- CNT_W, 16, width of each error counter.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- mem_adr  in  XLEN  CPU address.
- mem_d  in  XLEN  CPU write data.
- mem_req  in  1  CPU request strobe.
- mem_we  in  1  CPU write enable.
- mem_be  in  XLEN/8  CPU byte enables.
- mem_misaligned  in  1  request rejected by CPU-side alignment check.
- HSEL  in  1  AHB select.
- HADDR  in  PHYS_ADDR_SIZE  AHB address.
- HWDATA  in  XLEN  AHB write data.
- HWRITE  in  1  AHB direction.
- HSIZE  in  3  AHB transfer size.
- HTRANS  in  2  AHB transfer type.
- HREADY  in  1  AHB ready.
- HRESP  in  1  AHB error response.
- pending  out  $clog2(DEPTH)+1  current number of outstanding entries.
- err_addr_cnt, err_write_cnt, err_size_cnt, err_wdata_cnt, err_resp_cnt  out  CNT_W each  mismatch counters.
- overflow  out  1  sticky: a push arrived while full.
- underflow  out  1  sticky: an AHB transfer arrived with no expected entry.
- err_any  out  1  OR of all counters being non-zero, plus overflow and underflow.

Behaviour:
- Reset (HRESETn low, asynchronous):
  - FIFO emptied, pending=0.
  - All counters 0; overflow, underflow and err_any 0.
  - Data-phase register invalid.
  - Asserting reset mid-operation discards all pending entries and any in-flight data phase.
- Push, at rising HCLK:
  - Condition: mem_req=1 and mem_misaligned=0.
  - Stores {adr, we, be, d}.
  - Misaligned requests are never pushed.
- Pop, at rising HCLK:
  - Condition: HREADY=1, HSEL=1 and HTRANS is NONSEQ or SEQ.
  - HTRANS IDLE or BUSY never pops.
- Push and pop in the same cycle:
  - Both occur; pending is unchanged.
  - An entry pushed in a cycle is not visible to a pop in that same cycle (no bypass).
- Full:
  - Push without a simultaneous pop: entry dropped, overflow set.
  - Push with a simultaneous pop is legal.
- Empty: a pop sets underflow; no comparison is made and no data phase is armed.
- Address-phase checks on pop, in the same cycle:
  - HADDR !== adr[PHYS_ADDR_SIZE-1:0] -> err_addr_cnt +1.
  - HWRITE !== we -> err_write_cnt +1.
  - HSIZE compared with be2size(be):
    - 1 enabled byte -> 0.
    - 2 contiguous aligned bytes -> 1.
    - 4 -> 2.
    - 8 -> 3 (only when XLEN=64).
  - Mismatch, or a non-encodable be, -> err_size_cnt +1.
- Data phase:
  - The popped entry is loaded into the data-phase register (valid=1).
  - It completes at the first rising edge where HREADY=1.
  - Wait states (HREADY=0) hold the register.
  - On completion:
    - If we=1, compare HWDATA against d on enabled byte lanes only; mismatch -> err_wdata_cnt +1.
    - If HRESP=1, err_resp_cnt +1.
- Pipelining: an address-phase pop in the completing cycle reloads the register (back-to-back transfers); otherwise valid clears.
- Two-cycle error response: the first HRESP=1 cycle has HREADY=0 and only holds the register; the single count occurs in the HREADY=1 cycle.
- Multiple checks in one cycle: each counter updates independently.
- Counters saturate at 2^CNT_W-1. Sticky flags clear only on reset.
- All outputs are registered; they update one edge after the triggering event.

Optional Feature:
- Macro: SOC_RISCV_CHECK_CPU2AHB_DISPLAY_EN.
- Defined: each counter increment, overflow or underflow also issues $display("ERROR  : ...") with the got/expected values and $time.
- Undefined: silent; the module is synthesizable and free of non-synthesizable constructs.

Decomposition:
- Shared package peripheral_ahb4_verilog_pkg:
  - HTRANS_* and HSIZE_* constants, already present.
  - New: entry struct type parametrised via localparam widths.
  - New: function be2size returning {valid, size}.
- Sub-module soc_riscv_check_fifo:
  - Parametrised DEPTH/WIDTH sync FIFO.
  - push/pop/full/empty/count, with overflow/underflow pulses.
  - The scoreboard instantiates it once.

Test Plan:
- Write mem_adr=0x100, be=4'hF, d=0xDEADBEEF; AHB NONSEQ HADDR=0x100, HSIZE=2, HWRITE=1, HWDATA=0xDEADBEEF -> all counters 0, pending 1->0.
- Four back-to-back reads (0x0,0x4,0x8,0xC), pops with 2 wait states each -> pending peaks at 4, no errors; a fifth push while full without pop -> overflow=1, pending stays 4.
- Byte write be=4'b0100, d=0x00AB0000; AHB HWDATA=0xFFABFFFF, HSIZE=0 -> err_wdata_cnt=0 (masked lanes), err_size_cnt=0; repeat with HSIZE=2 -> err_size_cnt=1.
- AHB NONSEQ with HADDR=0x200 against expected 0x204 -> err_addr_cnt=1, err_any=1; NONSEQ with FIFO empty -> underflow=1, other counters unchanged.
- Two-cycle error response (HRESP=1, HREADY=0 then HREADY=1) -> err_resp_cnt=1 exactly; mem_misaligned=1 request -> nothing pushed.
- Assert HRESETn=0 with pending=3 mid data phase -> all outputs 0 immediately; after release, a new transfer checks cleanly with no underflow.
